serial_ripple_subtractor: RTL and testbench

- Bit-serial counterpart to the combinational ripple adder chain: computes X - Y - Borrowin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- Operands enter on a start/busy/done handshake. Results are registered and held until the next operation.
- Used where subtract area matters more than latency, e.g. the datapath of the team's sequential divider and comparator.

---
 rtl/sub_pkg.sv | 29 ++
 rtl/full_subtractor_1.sv | 17 +
 rtl/serial_ripple_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor family: FSM state encoding
// and the counter-width helper used to size the bit counter.
package sub_pkg;

    // Operation phases of the bit-serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bits needed to count 0 .. n-1; never less than one so that the
    // counter stays a real vector at the smallest legal width.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : sub_pkg

// File: rtl/full_subtractor_1.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit
// position had to borrow from the next higher position.
module full_subtractor_1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference is the plain parity of the three inputs.
    assign d    = a ^ b ^ bin;

    // Borrow when a=0,b=1 outright, or when a==b and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor_1

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: X - Y - Borrowin, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow. Operands
// are taken on a start in IDLE; results are registered and held until the
// next operation completes.
module serial_ripple_subtractor
    import sub_pkg::*;
#(
    parameter int chainnumber = 8
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   start,
    input  logic [chainnumber-1:0] X,
    input  logic [chainnumber-1:0] Y,
    input  logic                   Borrowin,
    output logic                   busy,
    output logic                   done,
    output logic [chainnumber-1:0] Difference,
    output logic                   Borrowout,
    output logic                   Overflow
);

    localparam int cw = clog2(chainnumber);

    typedef logic [cw-1:0] cnt_t;

    localparam cnt_t last_cnt = cnt_t'(chainnumber - 1);

    state_t                 state;
    logic [chainnumber-1:0] xsh;
    logic [chainnumber-1:0] ysh;
    // Holds the already-computed difference bits. The bit produced on the
    // final edge goes straight into Difference, so only chainnumber-1 bits
    // ever need to wait here.
    logic [chainnumber-2:0] dsh;
    logic                   brw;
    cnt_t                   cnt;
    logic                   xmsb;
    logic                   ymsb;

    logic                   d;
    logic                   b;
    logic [chainnumber-1:0] dsh_next;

    // The single arithmetic cell, fed from the LSBs of the operand shifters.
    full_subtractor_1 u_cell (
        .a    (xsh[0]),
        .b    (ysh[0]),
        .bin  (brw),
        .d    (d),
        .bout (b)
    );

    // New difference bit enters at the MSB; the full-width view is what
    // Difference receives on the last bit.
    assign dsh_next = {d, dsh};

    // Sequencer, operand/result shifters and registered outputs.
    // NOTE: every register here uses <= so all updates on an edge see the
    // pre-edge values; a blocking = would let later lines read new values.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            xsh        <= '0;
            ysh        <= '0;
            dsh        <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            xmsb       <= 1'b0;
            ymsb       <= 1'b0;
            Difference <= '0;
            Borrowout  <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        xsh   <= X;
                        ysh   <= Y;
                        brw   <= Borrowin;
                        xmsb  <= X[chainnumber-1];
                        ymsb  <= Y[chainnumber-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    dsh <= dsh_next[chainnumber-1:1];
                    xsh <= {1'b0, xsh[chainnumber-1:1]};
                    ysh <= {1'b0, ysh[chainnumber-1:1]};
                    brw <= b;
                    cnt <= cnt + cnt_t'(1);
                    if (cnt == last_cnt) begin
                        Difference <= dsh_next;
                        Borrowout  <= b;
                        // Signed overflow: operands of opposite sign and the
                        // result sign differs from the minuend's sign.
                        Overflow   <= (xmsb != ymsb) && (d != xmsb);
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_ripple_subtractor

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor at chainnumber = 8.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
module tb_serial_ripple_subtractor;

    localparam int w = 8;

    logic         clk1;
    logic         rst;
    logic         start;
    logic [w-1:0] X;
    logic [w-1:0] Y;
    logic         Borrowin;
    logic         busy;
    logic         done;
    logic [w-1:0] Difference;
    logic         Borrowout;
    logic         Overflow;

    int vectors;
    int miscompares;

    serial_ripple_subtractor #(.chainnumber(w)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .start      (start),
        .X          (X),
        .Y          (Y),
        .Borrowin   (Borrowin),
        .busy       (busy),
        .done       (done),
        .Difference (Difference),
        .Borrowout  (Borrowout),
        .Overflow   (Overflow)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present operands at the falling edge and let the next rising edge
    // (edge 0) accept them; start drops just after that edge.
    task automatic issue(input logic [w-1:0] xv, input logic [w-1:0] yv,
                         input logic bv);
        @(negedge clk1);
        X        = xv;
        Y        = yv;
        Borrowin = bv;
        start    = 1'b1;
        @(posedge clk1);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for the done pulse, then let DONE return to IDLE.
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk1);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(posedge clk1);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [w-1:0] dexp,
                                input logic bexp, input logic oexp);
        check({tag, "_diff"}, 64'(Difference), 64'(dexp));
        check({tag, "_bout"}, 64'(Borrowout), 64'(bexp));
        check({tag, "_ovf"},  64'(Overflow),  64'(oexp));
    endtask

    initial begin
        int done_count;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        X           = '0;
        Y           = '0;
        Borrowin    = 1'b0;

        // Reset state
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_diff", 64'(Difference), 64'd0);
        check("rst_bout", 64'(Borrowout), 64'd0);
        check("rst_ovf",  64'(Overflow), 64'd0);
        @(negedge clk1);
        @(negedge clk1);
        rst = 1'b0;

        // 5A - 3C with exact cycle timing: busy after edges 0..8, done only
        // after edge 8, both low after edge 9.
        issue(8'h5A, 8'h3C, 1'b0);
        check("t1_busy_e0", 64'(busy), 64'd1);
        check("t1_done_e0", 64'(done), 64'd0);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk1);
            #1;
            check($sformatf("t1_busy_e%0d", e), 64'(busy), (e <= 8) ? 64'd1 : 64'd0);
            check($sformatf("t1_done_e%0d", e), 64'(done), (e == 8) ? 64'd1 : 64'd0);
            if (e == 4) check("t1_hold_diff", 64'(Difference), 64'h00);
        end
        check_result("t1", 8'h1E, 1'b0, 1'b0);

        // Unsigned wrap-around with borrow out
        issue(8'h00, 8'h01, 1'b0);
        wait_done("t2");
        check_result("t2", 8'hFF, 1'b1, 1'b0);

        // Signed overflow: -128 - 1
        issue(8'h80, 8'h01, 1'b0);
        wait_done("t3");
        check_result("t3", 8'h7F, 1'b0, 1'b1);

        // Borrow-in consumed exactly
        issue(8'h10, 8'h0F, 1'b1);
        wait_done("t4");
        check_result("t4", 8'h00, 1'b0, 1'b0);

        // Equal operands with borrow-in give all ones
        issue(8'h33, 8'h33, 1'b1);
        wait_done("t5");
        check_result("t5", 8'hFF, 1'b1, 1'b0);

        // Starts at edges 3 and 9 (SHIFT and DONE) must be ignored
        issue(8'h20, 8'h05, 1'b0);
        done_count = 0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk1);
            if (e == 3 || e == 9) begin
                X     = 8'hFF;
                Y     = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk1);
            #1;
            if (done === 1'b1) done_count++;
            if (e == 5) check("t6_hold_diff", 64'(Difference), 64'hFF);
            if (e == 10) check("t6_idle_e10", 64'(busy), 64'd0);
        end
        start = 1'b0;
        check("t6_done_count", 64'(done_count), 64'd1);
        check_result("t6", 8'h1B, 1'b0, 1'b0);

        // Asynchronous reset mid-operation, between edges 4 and 5
        issue(8'h5A, 8'h3C, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk1);
        end
        #2;
        rst = 1'b1;
        #1;
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_done", 64'(done), 64'd0);
        check_result("t7", 8'h00, 1'b0, 1'b0);
        @(negedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        done_count = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk1);
            #1;
            if (done === 1'b1) done_count++;
        end
        check("t7_no_done", 64'(done_count), 64'd0);
        check("t7_idle_busy", 64'(busy), 64'd0);

        // Normal operation after the aborted one
        issue(8'h09, 8'h04, 1'b0);
        wait_done("t8");
        check_result("t8", 8'h05, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_ripple_subtractor
